// File: rtl/frame_draw_if.sv
// Bus between the frame sequencer and its datapath neighbours:
// primitive ROM address, rasterizer req/ack handshake and depth-memory clear port.
interface frame_draw_if #(
    parameter int ADDR_W     = 4,
    parameter int CLR_ADDR_W = 17,
    parameter int DEPTH_W    = 8
) ();
    logic [ADDR_W-1:0]     rom_addr;
    logic                  raster_req;
    logic                  raster_ack;
    logic                  clr_we;
    logic [CLR_ADDR_W-1:0] clr_addr;
    logic [DEPTH_W-1:0]    clr_data;

    modport master (
        output rom_addr,
        output raster_req,
        input  raster_ack,
        output clr_we,
        output clr_addr,
        output clr_data
    );

    modport slave (
        input  rom_addr,
        input  raster_req,
        output raster_ack,
        input  clr_we,
        input  clr_addr,
        input  clr_data
    );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Z-buffer frame sequencer: key press/release -> depth clear -> primitive issue -> frame_done.
// Optional ack watchdog enabled by defining ACK_TIMEOUT_EN.
module frame_draw_sequencer #(
    parameter int N_PRIM     = 16,
    parameter int ADDR_W     = 4,
    parameter int CLR_WORDS  = 76800,
    parameter int CLR_ADDR_W = 17,
`ifdef ACK_TIMEOUT_EN
    parameter int DEPTH_W    = 8,
    parameter int ACK_TIMEOUT = 4096
`else
    parameter int DEPTH_W    = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_key,
    frame_draw_if.master     bus,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CLEAR,
        S_REQ,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0]     PRIM_LAST = ADDR_W'(N_PRIM - 1);
    localparam logic [CLR_ADDR_W-1:0] CLR_LAST  = CLR_ADDR_W'(CLR_WORDS - 1);

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     rom_addr, rom_addr_nxt;
    logic [CLR_ADDR_W-1:0] clr_addr, clr_addr_nxt;
    logic                  key_p0, key_p1;
    logic                  key_s;
    logic                  timeout;
    logic                  clr_we_c, raster_req_c, busy_c, frame_done_c;

    // Two-flop synchronizer for the raw pushbutton; preset to "released"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
        end else begin
            key_p0 <= start_key;
            key_p1 <= key_p0;
        end
    end

    assign key_s = key_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            rom_addr <= rom_addr_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rom_addr_nxt = rom_addr;
        clr_addr_nxt = clr_addr;
        clr_we_c     = 1'b0;
        raster_req_c = 1'b0;
        busy_c       = 1'b1;
        frame_done_c = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (!key_s) state_nxt = S_ARM;
            end
            S_ARM: begin
                busy_c = 1'b0;
                if (key_s) begin
                    state_nxt    = S_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            S_CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_addr == CLR_LAST) begin
                    state_nxt    = S_REQ;
                    clr_addr_nxt = '0;
                    rom_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + 1'b1;
                end
            end
            // A stale ack from the previous primitive must clear before a new request
            S_REQ: begin
                if (!bus.raster_ack) state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                raster_req_c = 1'b1;
                if (bus.raster_ack || timeout) state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!bus.raster_ack || timeout) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (rom_addr == PRIM_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    rom_addr_nxt = rom_addr + 1'b1;
                    state_nxt    = S_REQ;
                end
            end
            S_DONE: begin
                frame_done_c = 1'b1;
                rom_addr_nxt = '0;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef ACK_TIMEOUT_EN
    localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

    logic [WD_W-1:0] wdog;
    logic            wdog_hit;
    logic            wd_restart;
    logic            err_q;

    assign wdog_hit   = (wdog == WD_LAST);
    assign wd_restart = (state_nxt != state) &&
                        ((state_nxt == S_WAIT_ACK) || (state_nxt == S_WAIT_REL));
    // Timeout only counts when the awaited ack edge has not arrived this cycle
    assign timeout    = wdog_hit &&
                        (((state == S_WAIT_ACK) && !bus.raster_ack) ||
                         ((state == S_WAIT_REL) &&  bus.raster_ack));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wd_restart)     wdog <= '0;
            else if (!wdog_hit) wdog <= wdog + 1'b1;
            if (timeout)        err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign bus.rom_addr   = rom_addr;
    assign bus.raster_req = raster_req_c;
    assign bus.clr_we     = clr_we_c;
    assign bus.clr_addr   = clr_addr;
    assign bus.clr_data   = '1;
    assign busy           = busy_c;
    assign frame_done     = frame_done_c;

endmodule
